// File: rtl/decode_stage.sv
// Pipeline ID stage: register file, control/ALU decode, immediate extension and the ID/EX register.
// Optional DECODE_ILLEGAL_EN adds IllegalE, flagging non-zero instructions with unsupported opcodes.
module decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] ImmExtE,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,
    output logic [XLEN-1:0] PCE,
`ifdef DECODE_ILLEGAL_EN
    output logic            IllegalE,
`endif
    output logic [XLEN-1:0] PCPlus4E
);

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpBeq   = 7'b1100011;
    localparam logic [6:0] OpIAlu  = 7'b0010011;
    localparam logic [6:0] OpJal   = 7'b1101111;

    typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmJ} imm_src_e;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } alu_op_e;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluSlt = 3'b101
    } alu_ctrl_e;

    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic            alu_src;
        logic [1:0]      result_src;
        logic [2:0]      alu_control;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm_ext;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
`ifdef DECODE_ILLEGAL_EN
        logic            illegal;
`endif
    } id_ex_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode    = InstrD[6:0];
    assign rd        = InstrD[11:7];
    assign funct3    = InstrD[14:12];
    assign rs1       = InstrD[19:15];
    assign rs2       = InstrD[24:20];
    assign funct7_b5 = InstrD[30];

    // Main control decoder
    logic      reg_write;
    logic      mem_write;
    logic      alu_src;
    logic      branch;
    logic      jump;
    logic [1:0] result_src;
    imm_src_e  imm_src;
    alu_op_e   alu_op;

    always_comb begin
        reg_write  = 1'b0;
        imm_src    = ImmNone;
        alu_src    = 1'b0;
        mem_write  = 1'b0;
        result_src = 2'b00;
        branch     = 1'b0;
        alu_op     = AluOpAdd;
        jump       = 1'b0;
        case (opcode)
            OpLoad: begin
                reg_write  = 1'b1;
                imm_src    = ImmI;
                alu_src    = 1'b1;
                result_src = 2'b01;
            end
            OpStore: begin
                imm_src   = ImmS;
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OpRType: begin
                reg_write = 1'b1;
                alu_op    = AluOpFunct;
            end
            OpBeq: begin
                imm_src = ImmB;
                branch  = 1'b1;
                alu_op  = AluOpSub;
            end
            OpIAlu: begin
                reg_write = 1'b1;
                imm_src   = ImmI;
                alu_src   = 1'b1;
                alu_op    = AluOpFunct;
            end
            OpJal: begin
                reg_write  = 1'b1;
                imm_src    = ImmJ;
                result_src = 2'b10;
                jump       = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU decoder; funct7[5] selects sub only for R-type, so addi with imm[10]=1 stays add
    alu_ctrl_e alu_control;

    always_comb begin
        alu_control = AluAdd;
        case (alu_op)
            AluOpSub: alu_control = AluSub;
            AluOpFunct: begin
                case (funct3)
                    3'b000:  alu_control = (opcode == OpRType && funct7_b5) ? AluSub : AluAdd;
                    3'b010:  alu_control = AluSlt;
                    3'b110:  alu_control = AluOr;
                    3'b111:  alu_control = AluAnd;
                    default: alu_control = AluAdd;
                endcase
            end
            default: alu_control = AluAdd;
        endcase
    end

    // Immediate extender
    logic [XLEN-1:0] imm_ext;

    always_comb begin
        imm_ext = '0;
        case (imm_src)
            ImmI: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            ImmS: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            ImmB: imm_ext = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25],
                             InstrD[11:8], 1'b0};
            ImmJ: imm_ext = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20],
                             InstrD[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

    // Register file with write-through so a same-cycle writeback is seen by decode
    logic [XLEN-1:0] rf_q [NREGS];
    logic            wb_en;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    assign wb_en = RegWriteW && (RdW != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en) begin
            rf_q[RdW] <= ResultW;
        end
    end

    always_comb begin
        if (rs1 == 5'd0) begin
            rd1 = '0;
        end else if (wb_en && (RdW == rs1)) begin
            rd1 = ResultW;
        end else begin
            rd1 = rf_q[rs1];
        end
    end

    always_comb begin
        if (rs2 == 5'd0) begin
            rd2 = '0;
        end else if (wb_en && (RdW == rs2)) begin
            rd2 = ResultW;
        end else begin
            rd2 = rf_q[rs2];
        end
    end

    // ID/EX register; a flush clears the whole bundle, not just control
    id_ex_t id_ex_d;
    id_ex_t id_ex_q;

    always_comb begin
        id_ex_d             = '0;
        id_ex_d.reg_write   = reg_write;
        id_ex_d.mem_write   = mem_write;
        id_ex_d.jump        = jump;
        id_ex_d.branch      = branch;
        id_ex_d.alu_src     = alu_src;
        id_ex_d.result_src  = result_src;
        id_ex_d.alu_control = alu_control;
        id_ex_d.rd1         = rd1;
        id_ex_d.rd2         = rd2;
        id_ex_d.imm_ext     = imm_ext;
        id_ex_d.rs1         = rs1;
        id_ex_d.rs2         = rs2;
        id_ex_d.rd          = rd;
        id_ex_d.pc          = PCD;
        id_ex_d.pc_plus4    = PCPlus4D;
`ifdef DECODE_ILLEGAL_EN
        id_ex_d.illegal     = (opcode != OpLoad) && (opcode != OpStore) && (opcode != OpRType) &&
                              (opcode != OpBeq) && (opcode != OpIAlu) && (opcode != OpJal) &&
                              (InstrD != 32'd0);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex_q <= '0;
        end else if (FlushE) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign RegWriteE   = id_ex_q.reg_write;
    assign MemWriteE   = id_ex_q.mem_write;
    assign JumpE       = id_ex_q.jump;
    assign BranchE     = id_ex_q.branch;
    assign ALUSrcE     = id_ex_q.alu_src;
    assign ResultSrcE  = id_ex_q.result_src;
    assign ALUControlE = id_ex_q.alu_control;
    assign RD1E        = id_ex_q.rd1;
    assign RD2E        = id_ex_q.rd2;
    assign ImmExtE     = id_ex_q.imm_ext;
    assign Rs1E        = id_ex_q.rs1;
    assign Rs2E        = id_ex_q.rs2;
    assign RdE         = id_ex_q.rd;
    assign PCE         = id_ex_q.pc;
    assign PCPlus4E    = id_ex_q.pc_plus4;
`ifdef DECODE_ILLEGAL_EN
    assign IllegalE    = id_ex_q.illegal;
`endif

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline ID stage plus the ID/EX register.
- Consumes InstrD/PCD/PCPlus4D from the fetch stage.
- Contains the 32x32 register file, main/ALU control decoder and immediate extender.
- Registers everything toward execute; writeback drives the regfile write port.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, register count (x0 hardwired zero).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- InstrD  in  32  instruction from fetch
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PCD+4
- RegWriteW  in  1  writeback enable
- RdW  in  5  writeback destination
- ResultW  in  32  writeback data
- FlushE  in  1  insert bubble into EX
- RegWriteE  out  1  EX regfile write enable
- MemWriteE  out  1  store
- JumpE  out  1  jal
- BranchE  out  1  beq
- ALUSrcE  out  1  1 = ImmExtE as ALU operand B
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- RD1E, RD2E  out  32  register operands
- ImmExtE  out  32  sign-extended immediate
- Rs1E, Rs2E, RdE  out  5  register indices (for hazard unit)
- PCE, PCPlus4E  out  32  passed-through PCs

Behaviour:
- Reset (rst=0, asynchronous):
  - All E outputs = 0.
  - All registers x1..x31 = 0.
- Latency: one clk. E outputs reflect the InstrD present before the rising edge.
- Supported opcodes, each as control {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump}:
  - 0000011 lw: 1, I, 1, 0, 01, 0, 00, 0
  - 0100011 sw: 0, S, 1, 1, xx→00, 0, 00, 0
  - 0110011 R-type: 1, –, 0, 0, 00, 0, 10, 0
  - 1100011 beq: 0, B, 0, 0, 00, 1, 01, 0
  - 0010011 I-ALU: 1, I, 1, 0, 00, 0, 10, 0
  - 1101111 jal: 1, J, –, 0, 10, 0, 00, 1
  - Any other opcode, including 0x00000000 from fetch reset: all controls 0 (bubble).
- ALU decode:
  - ALUOp 00 → add; 01 → sub.
  - ALUOp 10 by funct3:
    - 000 → sub only if opcode=R-type and funct7[5]=1, else add.
    - 010 → slt; 110 → or; 111 → and.
    - Others → add.
- Immediates (sign bit = Instr[31]):
  - I = Instr[31:20].
  - S = {Instr[31:25], Instr[11:7]}.
  - B = {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}.
  - J = {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}.
  - Unsupported opcode → 0.
- Register file:
  - Write on rising clk when RegWriteW=1 and RdW≠0. Writes to x0 ignored; x0 always reads 0.
  - Reads are combinational from Instr[19:15]/Instr[24:20].
  - Internal write-through: if RegWriteW=1, RdW≠0 and RdW equals a read index in the same cycle, that operand takes ResultW. No stale read across the writeback/decode overlap.
- FlushE=1 at a rising edge:
  - All E outputs are loaded with 0 (full bubble, not control-only).
  - Regfile write still occurs that cycle.
- Reset mid-operation: immediate return to reset values; any pending write is dropped.

Optional Feature:
- Macro: DECODE_ILLEGAL_EN
- Defined:
  - Adds output IllegalE (1 bit, reset 0).
  - Registered high for one cycle when InstrD has an unsupported opcode and InstrD≠0x00000000.
  - Cleared by FlushE.
- Undefined: port absent; unsupported opcodes are silently bubbled.

Test Plan:
- Reset and NOP:
  - Assert rst=0 mid-run → all E outputs 0 immediately.
  - Release with InstrD=0 → outputs stay 0.
- Writeback then I-ALU:
  - Write x1=0x11111111 via RegWriteW/RdW=1.
  - Then InstrD=0x00500093 (addi x1,x0,5) → RegWriteE=1, ALUSrcE=1, ImmExtE=5, RdE=1, Rs1E=0, RD1E=0, ALUControlE=000.
- Write-through bypass:
  - Same cycle: RegWriteW=1, RdW=3, ResultW=0xDEADBEEF, InstrD=0x00018233 (add x4,x3,x0).
  - Next edge → RD1E=0xDEADBEEF, RD2E=0, RdE=4, ALUControlE=000.
- Branch:
  - InstrD=0xFE208EE3 (beq x1,x2,-4), PCD=0x40.
  - → BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFFC, Rs1E=1, Rs2E=2, PCE=0x40, RegWriteE=0.
- x0 write:
  - RegWriteW=1, RdW=0, ResultW=0x1234.
  - Then decode add x4,x0,x0 → RD1E=RD2E=0.
- Flush:
  - InstrD=0x0020A423 (sw x2,8(x1)) with FlushE=1 → all outputs 0.
  - Same instruction, FlushE=0 → MemWriteE=1, ImmExtE=8, Rs1E=1, Rs2E=2.
